// File: rtl/lsu_pkg.sv
// ============================================================================
// Module : lsu_pkg
// Brief  : Shared types and decode helpers for the load/store unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package lsu_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd3,
    LHU = 3'd4,
    SB  = 3'd5,
    SH  = 3'd6,
    SW  = 3'd7
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  function automatic logic is_store(mem_op_e op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  function automatic logic [2:0] access_bytes(mem_op_e op);
    case (op)
      LB, LBU, SB: return 3'd1;
      LH, LHU, SH: return 3'd2;
      default:     return 3'd4;
    endcase
  endfunction

  // Halfwords need addr[0]=0, words need addr[1:0]=0.
  function automatic logic is_misaligned(mem_op_e op, logic [1:0] lsb);
    case (access_bytes(op))
      3'd2:    return lsb[0];
      3'd4:    return |lsb;
      default: return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_extend.sv
// ============================================================================
// Module : load_extend
// Brief  : Combinational sign/zero extension of a little-endian load word.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module load_extend
  import lsu_pkg::*;
(
  input  mem_op_e     op,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  always_comb begin
    data = raw;
    case (op)
      LB:      data = {{24{raw[7]}}, raw[7:0]};
      LBU:     data = {24'd0, raw[7:0]};
      LH:      data = {{16{raw[15]}}, raw[15:0]};
      LHU:     data = {16'd0, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module : load_store_unit
// Brief  : Single-outstanding load/store controller for the unified memory.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int DATA_INDEXING_WIDTH = $clog2(DATA_WIDTH / 8)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  mem_op_e                      req_op,
  input  logic [ADDR_WIDTH-1:0]        req_addr,
  input  logic [DATA_WIDTH-1:0]        req_wdata,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [DATA_WIDTH-1:0]        resp_data,
  output logic                         resp_err,
  output logic [ADDR_WIDTH-1:0]        mem_fetch_addr,
  output logic [ADDR_WIDTH-1:0]        mem_write_addr,
  output logic [DATA_INDEXING_WIDTH:0] mem_bytes_to_write,
  output logic [DATA_WIDTH-1:0]        mem_write_data,
  input  logic [DATA_WIDTH-1:0]        mem_fetched_data
);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("load_store_unit supports DATA_WIDTH=32 only");
  end

  lsu_state_e            r_state;
  lsu_state_e            w_next;
  mem_op_e               r_op;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_resp_data;
  logic                  r_resp_err;
  logic [DATA_WIDTH-1:0] w_ext;
  logic                  w_misaligned;

  load_extend u_load_extend (
    .op   (r_op),
    .raw  (mem_fetched_data),
    .data (w_ext)
  );

  assign w_misaligned = is_misaligned(r_op, r_addr[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Byte count is decoded from state so a reset mid-ACCESS kills the write at once.
  always_comb begin
    w_next             = r_state;
    req_ready          = 1'b0;
    resp_valid         = 1'b0;
    mem_bytes_to_write = '0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = ACCESS;
      end
      ACCESS: begin
        w_next = RESP;
        if (is_store(r_op) && !w_misaligned)
          mem_bytes_to_write = access_bytes(r_op);
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op        <= LB;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
    end else begin
      if (r_state == IDLE && req_valid) begin
        r_op    <= req_op;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (r_state == ACCESS) begin
        r_resp_err  <= w_misaligned;
        r_resp_data <= (w_misaligned || is_store(r_op)) ? '0 : w_ext;
      end
    end
  end

  assign resp_data      = r_resp_data;
  assign resp_err       = r_resp_err;
  assign mem_fetch_addr = r_addr;
  assign mem_write_addr = r_addr;
  assign mem_write_data = r_wdata;

endmodule

`default_nettype wire
